tug_scoreboard: RTL and testbench

Match scoreboard sitting directly downstream of the tug-of-war `playfield`. It consumes the playfield's `winner` flags, and keeps a per-player round count. It drives the playfield's round reset so each new round starts from centre, and shows both scores on two seven-segment digits. A match ends when either player reaches `MAX_SCORE`; the board then freezes until `restart` or reset.

---
 rtl/tug_scoreboard_if.sv | 26 ++
 rtl/tug_scoreboard.sv | 192 +++++++++++++++++++
 tb/tb_tug_scoreboard.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/tug_scoreboard_if.sv
// Scoreboard port bundle: playfield win flags and restart in, round reset,
// scores, seven-segment digits and match status out.
// master = side that drives winner/restart (playfield + match control), slave = scoreboard.
interface tug_scoreboard_if;
  logic [1:0] winner;        // 2'b10 left won, 2'b01 right won, else no winner
  logic       restart;       // start a new match (only acted on once the match is over)
  logic       round_reset;   // registered reset to the playfield
  logic [2:0] score_left;
  logic [2:0] score_right;
  logic [6:0] hex_left;      // active-low {g,f,e,d,c,b,a}
  logic [6:0] hex_right;     // active-low {g,f,e,d,c,b,a}
  logic       match_over;
  logic [1:0] match_winner;  // same encoding as winner, 2'b00 until decided

  modport master (
    output winner, restart,
    input  round_reset, score_left, score_right, hex_left, hex_right,
           match_over, match_winner
  );

  modport slave (
    input  winner, restart,
    output round_reset, score_left, score_right, hex_left, hex_right,
           match_over, match_winner
  );
endinterface

// File: rtl/tug_scoreboard.sv
// Purpose: tug-of-war match scoreboard; counts round wins, resets the playfield between rounds.
// Latency: a valid winner updates the score 1 cycle later; the playfield is back in play HOLD_CYCLES+2 cycles after the win.
// Backpressure: none; winner is a level flag consumed once per round, ignored outside PLAY.
//
// Ports: clk, reset_n (async active-low), sb (tug_scoreboard_if.slave):
//   in  winner[1:0], restart
//   out round_reset, score_left[2:0], score_right[2:0], hex_left[6:0], hex_right[6:0],
//       match_over, match_winner[1:0]
// Optional: define TUG_SCOREBOARD_FLASH_EN to flash the winner's digit while the match is over
//   (half-period FLASH_DIV cycles).
module tug_scoreboard #(
  parameter int HOLD_CYCLES = 4,  // 1..255
  parameter int MAX_SCORE   = 7,  // 1..7
  parameter int FLASH_DIV   = 8   // 1..255
) (
  input  logic            clk,
  input  logic            reset_n,
  tug_scoreboard_if.slave sb
);

  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
    $error("tug_scoreboard: HOLD_CYCLES out of range 1..255");
  end
  if (MAX_SCORE < 1 || MAX_SCORE > 7) begin : g_bad_max
    $error("tug_scoreboard: MAX_SCORE out of range 1..7");
  end
  if (FLASH_DIV < 1 || FLASH_DIV > 255) begin : g_bad_flash
    $error("tug_scoreboard: FLASH_DIV out of range 1..255");
  end

  localparam logic [2:0] MAX_S     = 3'(MAX_SCORE);
  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_PLAY  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       armed;           // low only until the first edge after reset release
  logic       round_reset_q;
  logic       round_reset_d;
  logic       match_over_q;
  logic       match_over_d;
  logic [2:0] score_left_q;
  logic [2:0] score_right_q;
  logic [7:0] hold_cnt;
  logic [1:0] side_q;          // winner code of the round being held
  logic [1:0] match_winner_q;

  logic win_left;
  logic win_right;
  logic hold_done;
  logic side_at_max;
  logic restart_go;
  logic blank_left;
  logic blank_right;

  assign win_left    = (state == ST_PLAY) && (sb.winner == 2'b10);
  assign win_right   = (state == ST_PLAY) && (sb.winner == 2'b01);
  assign hold_done   = (state == ST_HOLD) && (hold_cnt == 8'd0);
  assign side_at_max = (side_q == 2'b10) ? (score_left_q == MAX_S) : (score_right_q == MAX_S);
  assign restart_go  = (state == ST_OVER) && sb.restart;

  // State register, plus the flopped outputs that follow the next state so
  // round_reset/match_over never glitch from a state decode.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_CLEAR;
      armed         <= 1'b0;
      round_reset_q <= 1'b1;
      match_over_q  <= 1'b0;
    end else begin
      state         <= state_nxt;
      armed         <= 1'b1;
      round_reset_q <= round_reset_d;
      match_over_q  <= match_over_d;
    end
  end

  // Next-state logic. CLEAR waits for 'armed' so the playfield sees a full
  // round_reset cycle after reset release; afterwards CLEAR is one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_CLEAR: if (armed) state_nxt = ST_PLAY;
      ST_PLAY:  if (win_left || win_right) state_nxt = ST_HOLD;
      ST_HOLD:  if (hold_done) state_nxt = side_at_max ? ST_OVER : ST_CLEAR;
      ST_OVER:  if (sb.restart) state_nxt = ST_CLEAR;
      default:  state_nxt = ST_CLEAR;
    endcase
  end

  // Output logic: next values of the registered outputs.
  always_comb begin
    round_reset_d = 1'b0;
    match_over_d  = 1'b0;
    if (state_nxt == ST_CLEAR || state_nxt == ST_OVER) begin
      round_reset_d = 1'b1;
    end
    if (state_nxt == ST_OVER) begin
      match_over_d = 1'b1;
    end
  end

  // Score, hold timer and match result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      score_left_q   <= 3'd0;
      score_right_q  <= 3'd0;
      hold_cnt       <= 8'd0;
      side_q         <= 2'b00;
      match_winner_q <= 2'b00;
    end else if (restart_go) begin
      score_left_q   <= 3'd0;
      score_right_q  <= 3'd0;
      match_winner_q <= 2'b00;
    end else if (win_left || win_right) begin
      // Saturation is a guard only: the match ends before a side can exceed MAX_SCORE.
      if (win_left && score_left_q != MAX_S) begin
        score_left_q <= score_left_q + 3'd1;
      end
      if (win_right && score_right_q != MAX_S) begin
        score_right_q <= score_right_q + 3'd1;
      end
      side_q   <= sb.winner;
      hold_cnt <= HOLD_LOAD;
    end else if (state == ST_HOLD) begin
      if (hold_cnt != 8'd0) begin
        hold_cnt <= hold_cnt - 8'd1;
      end else if (side_at_max) begin
        match_winner_q <= side_q;
      end
    end
  end

`ifdef TUG_SCOREBOARD_FLASH_EN
  // Flash timer runs only in OVER; held at zero elsewhere so the winner's
  // digit always starts visible on entry to OVER.
  logic [7:0] flash_cnt;
  logic       flash_blank;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flash_cnt   <= 8'd0;
      flash_blank <= 1'b0;
    end else if (state != ST_OVER || sb.restart) begin
      flash_cnt   <= 8'd0;
      flash_blank <= 1'b0;
    end else if (flash_cnt == 8'(FLASH_DIV - 1)) begin
      flash_cnt   <= 8'd0;
      flash_blank <= ~flash_blank;
    end else begin
      flash_cnt <= flash_cnt + 8'd1;
    end
  end

  assign blank_left  = flash_blank && (match_winner_q == 2'b10);
  assign blank_right = flash_blank && (match_winner_q == 2'b01);
`else
  assign blank_left  = 1'b0;
  assign blank_right = 1'b0;
`endif

  // Active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg7(input logic [2:0] v);
    logic [6:0] s;
    case (v)
      3'd0:    s = 7'b1000000;
      3'd1:    s = 7'b1111001;
      3'd2:    s = 7'b0100100;
      3'd3:    s = 7'b0110000;
      3'd4:    s = 7'b0011001;
      3'd5:    s = 7'b0010010;
      3'd6:    s = 7'b0000010;
      default: s = 7'b1111000;
    endcase
    return s;
  endfunction

  assign sb.round_reset  = round_reset_q;
  assign sb.match_over   = match_over_q;
  assign sb.match_winner = match_winner_q;
  assign sb.score_left   = score_left_q;
  assign sb.score_right  = score_right_q;
  assign sb.hex_left     = blank_left  ? 7'b1111111 : seg7(score_left_q);
  assign sb.hex_right    = blank_right ? 7'b1111111 : seg7(score_right_q);

endmodule

// File: tb/tb_tug_scoreboard.sv
module tb_tug_scoreboard;
  localparam int HOLD = 4;
  localparam int MAXS = 3;
  localparam int FDIV = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  tug_scoreboard_if bus ();

  tug_scoreboard #(
    .HOLD_CYCLES(HOLD),
    .MAX_SCORE  (MAXS),
    .FLASH_DIV  (FDIV)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .sb     (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [6:0] seg_tab [8];

  // Reference model: cycles left in the clearing phase, cycles left in the
  // hold phase, whether the match is over, and the scores as plain integers.
  int m_sc [2];      // [0] left, [1] right
  int m_clear;
  int m_hold;
  int m_side;        // 0 left, 1 right
  int m_mw;          // -1 none, 0 left, 1 right
  int m_over_cyc;    // cycles spent in OVER since entry
  bit m_over;

  task automatic model_reset();
    m_sc[0] = 0; m_sc[1] = 0;
    m_clear = 2;     // release edge keeps clearing, next edge starts play
    m_hold = 0; m_side = 0; m_mw = -1; m_over = 0; m_over_cyc = 0;
  endtask

  task automatic model_step(input logic [1:0] w, input logic rs);
    if (m_over) begin
      if (rs) begin
        m_sc[0] = 0; m_sc[1] = 0; m_mw = -1; m_over = 0; m_clear = 1;
      end else begin
        m_over_cyc++;
      end
    end else if (m_clear > 0) begin
      m_clear--;
    end else if (m_hold > 0) begin
      m_hold--;
      if (m_hold == 0) begin
        if (m_sc[m_side] == MAXS) begin
          m_over = 1; m_mw = m_side; m_over_cyc = 0;
        end else begin
          m_clear = 1;
        end
      end
    end else if (w == 2'b10 || w == 2'b01) begin
      m_side = (w == 2'b10) ? 0 : 1;
      if (m_sc[m_side] < MAXS) m_sc[m_side]++;
      m_hold = HOLD;
    end
  endtask

  function automatic logic exp_rr();
    return m_over || (m_clear > 0);
  endfunction

  function automatic logic [1:0] exp_mw();
    if (m_mw == 0) return 2'b10;
    if (m_mw == 1) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [6:0] exp_hex(input int s);
    logic [6:0] v;
    v = seg_tab[m_sc[s]];
`ifdef TUG_SCOREBOARD_FLASH_EN
    if (m_over && m_mw == s && ((m_over_cyc / FDIV) % 2 == 1)) v = 7'b1111111;
`endif
    return v;
  endfunction

  // Drive one cycle: inputs after the falling edge, model advances on the
  // rising edge, returns at the next falling edge for sampling.
  task automatic tick(input logic [1:0] w, input logic rs);
    bus.winner = w;
    bus.restart = rs;
    @(posedge clk);
    model_step(w, rs);
    @(negedge clk);
  endtask

  task automatic play_round(input logic [1:0] w);
    tick(w, 1'b0);
    repeat (HOLD) tick(w, 1'b0);
    if (!m_over) tick(2'b00, 1'b0);
  endtask

  task automatic test_reset();
    int rr_ones;
    bus.winner = 2'b00; bus.restart = 1'b0; reset_n = 1'b0;
    @(negedge clk); @(negedge clk);
    model_reset();
    checks++; if (bus.round_reset !== 1'b1) begin errors++; $display("FAIL reset_round_reset got %b want 1", bus.round_reset); end
    checks++; if (bus.score_left !== 3'd0 || bus.score_right !== 3'd0) begin errors++; $display("FAIL reset_scores got %0d/%0d want 0/0", bus.score_left, bus.score_right); end
    checks++; if (bus.hex_left !== 7'b1000000 || bus.hex_right !== 7'b1000000) begin errors++; $display("FAIL reset_hex got %b/%b want 1000000/1000000", bus.hex_left, bus.hex_right); end
    checks++; if (bus.match_over !== 1'b0 || bus.match_winner !== 2'b00) begin errors++; $display("FAIL reset_match got %b/%b want 0/00", bus.match_over, bus.match_winner); end
    reset_n = 1'b1;
    tick(2'b00, 1'b0);
    checks++; if (bus.round_reset !== 1'b1) begin errors++; $display("FAIL release_first_edge round_reset got %b want 1", bus.round_reset); end
    rr_ones = 0;
    for (int i = 0; i < 9; i++) begin
      tick(2'b00, 1'b0);
      if (bus.round_reset === 1'b1) rr_ones++;
    end
    checks++; if (rr_ones != 0) begin errors++; $display("FAIL idle_round_reset high cycles got %0d want 0", rr_ones); end
    checks++; if (bus.score_left !== 3'd0 || bus.score_right !== 3'd0) begin errors++; $display("FAIL idle_scores got %0d/%0d want 0/0", bus.score_left, bus.score_right); end
  endtask

  task automatic test_single_round();
    int hold_ticks;
    tick(2'b10, 1'b0);
    checks++; if (bus.score_left !== 3'd1) begin errors++; $display("FAIL win_score_left got %0d want 1", bus.score_left); end
    checks++; if (bus.hex_left !== 7'b1111001) begin errors++; $display("FAIL win_hex_left got %b want 1111001", bus.hex_left); end
    checks++; if (bus.round_reset !== 1'b0) begin errors++; $display("FAIL hold_round_reset got %b want 0", bus.round_reset); end
    hold_ticks = 0;
    for (int i = 0; i < 3 * HOLD && bus.round_reset === 1'b0; i++) begin
      tick(2'b10, 1'b0);
      hold_ticks++;
    end
    checks++; if (hold_ticks != HOLD) begin errors++; $display("FAIL hold_length got %0d want %0d", hold_ticks, HOLD); end
    tick(2'b00, 1'b0);
    checks++; if (bus.round_reset !== 1'b0) begin errors++; $display("FAIL clear_length round_reset got %b want 0", bus.round_reset); end
    checks++; if (bus.score_left !== 3'd1 || bus.score_right !== 3'd0) begin errors++; $display("FAIL no_double_count got %0d/%0d want 1/0", bus.score_left, bus.score_right); end
  endtask

  task automatic test_invalid();
    tick(2'b11, 1'b0);
    tick(2'b00, 1'b0);
    tick(2'b11, 1'b0);
    checks++; if (bus.score_left !== 3'd1 || bus.score_right !== 3'd0) begin errors++; $display("FAIL invalid_scores got %0d/%0d want 1/0", bus.score_left, bus.score_right); end
    // A valid code on the very next edge must count, so the block stayed in play.
    tick(2'b01, 1'b0);
    checks++; if (bus.score_right !== 3'd1) begin errors++; $display("FAIL invalid_then_valid score_right got %0d want 1", bus.score_right); end
    repeat (HOLD) tick(2'b00, 1'b0);
    tick(2'b00, 1'b0);
  endtask

  task automatic test_match_over();
    play_round(2'b01);
    checks++; if (bus.score_right !== 3'd2) begin errors++; $display("FAIL second_right_win got %0d want 2", bus.score_right); end
    play_round(2'b01);
    checks++; if (bus.score_right !== 3'd3 || bus.hex_right !== 7'b0110000) begin errors++; $display("FAIL third_right_win got %0d/%b want 3/0110000", bus.score_right, bus.hex_right); end
    checks++; if (bus.match_over !== 1'b1 || bus.match_winner !== 2'b01 || bus.round_reset !== 1'b1) begin errors++; $display("FAIL over_flags got mo=%b mw=%b rr=%b want 1/01/1", bus.match_over, bus.match_winner, bus.round_reset); end
    for (int i = 0; i < 4 * FDIV; i++) begin
      tick((i % 2 == 0) ? 2'b10 : 2'b01, 1'b0);
      checks++; if (bus.hex_right !== exp_hex(1)) begin errors++; $display("FAIL over_hex_right cycle %0d got %b want %b", i, bus.hex_right, exp_hex(1)); end
      checks++; if (bus.hex_left !== 7'b1111001) begin errors++; $display("FAIL over_hex_left cycle %0d got %b want 1111001", i, bus.hex_left); end
    end
    checks++; if (bus.score_left !== 3'd1 || bus.score_right !== 3'd3) begin errors++; $display("FAIL over_frozen got %0d/%0d want 1/3", bus.score_left, bus.score_right); end
    checks++; if (bus.round_reset !== 1'b1 || bus.match_over !== 1'b1) begin errors++; $display("FAIL over_held got rr=%b mo=%b want 1/1", bus.round_reset, bus.match_over); end
  endtask

  task automatic test_restart();
    tick(2'b00, 1'b1);
    checks++; if (bus.score_left !== 3'd0 || bus.score_right !== 3'd0 || bus.match_winner !== 2'b00) begin errors++; $display("FAIL restart_clear got %0d/%0d mw=%b want 0/0 00", bus.score_left, bus.score_right, bus.match_winner); end
    checks++; if (bus.round_reset !== 1'b1 || bus.match_over !== 1'b0) begin errors++; $display("FAIL restart_clear_cycle got rr=%b mo=%b want 1/0", bus.round_reset, bus.match_over); end
    tick(2'b00, 1'b0);
    checks++; if (bus.round_reset !== 1'b0) begin errors++; $display("FAIL restart_play round_reset got %b want 0", bus.round_reset); end
    tick(2'b00, 1'b1);
    checks++; if (bus.round_reset !== 1'b0 || bus.match_over !== 1'b0) begin errors++; $display("FAIL restart_in_play got rr=%b mo=%b want 0/0", bus.round_reset, bus.match_over); end
    tick(2'b10, 1'b0);
    checks++; if (bus.score_left !== 3'd1) begin errors++; $display("FAIL play_after_restart score_left got %0d want 1", bus.score_left); end
    repeat (HOLD) tick(2'b00, 1'b0);
    tick(2'b00, 1'b0);
  endtask

  task automatic test_reset_mid_hold();
    play_round(2'b10);
    tick(2'b01, 1'b0);
    tick(2'b00, 1'b0);
    checks++; if (bus.score_left !== 3'd2 || bus.score_right !== 3'd1 || bus.round_reset !== 1'b0) begin errors++; $display("FAIL pre_reset got %0d/%0d rr=%b want 2/1 rr=0", bus.score_left, bus.score_right, bus.round_reset); end
    reset_n = 1'b0;
    #1;
    checks++; if (bus.score_left !== 3'd0 || bus.score_right !== 3'd0 || bus.round_reset !== 1'b1) begin errors++; $display("FAIL async_reset got %0d/%0d rr=%b want 0/0 rr=1", bus.score_left, bus.score_right, bus.round_reset); end
    checks++; if (bus.hex_left !== 7'b1000000 || bus.hex_right !== 7'b1000000 || bus.match_over !== 1'b0 || bus.match_winner !== 2'b00) begin errors++; $display("FAIL async_reset_outputs got %b/%b mo=%b mw=%b", bus.hex_left, bus.hex_right, bus.match_over, bus.match_winner); end
    @(negedge clk);
    model_reset();
    reset_n = 1'b1;
  endtask

  task automatic test_random(input int n);
    logic [1:0] w;
    logic       rs;
    for (int i = 0; i < n; i++) begin
      w  = 2'($urandom_range(0, 3));
      rs = ($urandom_range(0, 7) == 0);
      tick(w, rs);
      checks++; if (bus.round_reset !== exp_rr()) begin errors++; $display("FAIL rnd_round_reset cyc %0d got %b want %b", i, bus.round_reset, exp_rr()); end
      checks++; if (bus.score_left !== 3'(m_sc[0])) begin errors++; $display("FAIL rnd_score_left cyc %0d got %0d want %0d", i, bus.score_left, m_sc[0]); end
      checks++; if (bus.score_right !== 3'(m_sc[1])) begin errors++; $display("FAIL rnd_score_right cyc %0d got %0d want %0d", i, bus.score_right, m_sc[1]); end
      checks++; if (bus.hex_left !== exp_hex(0)) begin errors++; $display("FAIL rnd_hex_left cyc %0d got %b want %b", i, bus.hex_left, exp_hex(0)); end
      checks++; if (bus.hex_right !== exp_hex(1)) begin errors++; $display("FAIL rnd_hex_right cyc %0d got %b want %b", i, bus.hex_right, exp_hex(1)); end
      checks++; if (bus.match_over !== m_over) begin errors++; $display("FAIL rnd_match_over cyc %0d got %b want %b", i, bus.match_over, m_over); end
      checks++; if (bus.match_winner !== exp_mw()) begin errors++; $display("FAIL rnd_match_winner cyc %0d got %b want %b", i, bus.match_winner, exp_mw()); end
    end
  endtask

  initial begin
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001;
    seg_tab[2] = 7'b0100100; seg_tab[3] = 7'b0110000;
    seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000;
    bus.winner = 2'b00;
    bus.restart = 1'b0;
    model_reset();
    test_reset();
    test_single_round();
    test_invalid();
    test_match_over();
    test_restart();
    test_reset_mid_hold();
    test_random(3000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end
endmodule
